// File: rtl/piso_rr_scheduler.sv
// Two-requester round-robin front end for a shared MSB-first serializer.
// Each granted word is shifted out with a valid strobe, followed by an optional idle gap.
module piso_rr_scheduler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sdo_src,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bitcnt;
  logic [3:0]       r_gapcnt;
  logic             r_sdo;
  logic             r_sdo_valid;
  logic             r_src;
  logic             r_frame_done;
  logic             r_last_grant;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_hs;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_hs_data;

  assign w_last_bit = (r_bitcnt == CW'(WIDTH));
  assign w_hs       = w_grant0 || w_grant1;
  assign w_hs_data  = w_grant1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_next   = r_state;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid && req1_valid) begin
          w_grant0 = r_last_grant;
          w_grant1 = !r_last_grant;
        end else begin
          w_grant0 = req0_valid;
          w_grant1 = req1_valid;
        end
        if (w_grant0 || w_grant1) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last_bit) w_next = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_gapcnt <= 4'd1) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The MSB is driven straight from the handshake data so it appears one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_gapcnt     <= '0;
      r_sdo        <= 1'b0;
      r_sdo_valid  <= 1'b0;
      r_src        <= 1'b0;
      r_frame_done <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_shift      <= {w_hs_data[WIDTH-2:0], 1'b0};
            r_sdo        <= w_hs_data[WIDTH-1];
            r_sdo_valid  <= 1'b1;
            r_bitcnt     <= CW'(1);
            r_src        <= w_grant1;
            r_last_grant <= w_grant1;
            r_frame_done <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_sdo        <= 1'b0;
            r_sdo_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_bitcnt     <= '0;
            r_gapcnt     <= 4'(GAP);
          end else begin
            r_sdo        <= r_shift[WIDTH-1];
            r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
            r_bitcnt     <= r_bitcnt + CW'(1);
            r_frame_done <= (r_bitcnt == CW'(WIDTH - 1));
          end
        end
        S_GAP: begin
          if (r_gapcnt != '0) r_gapcnt <= r_gapcnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign sdo        = r_sdo;
  assign sdo_valid  = r_sdo_valid;
  assign sdo_src    = r_src;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Bench for piso_rr_scheduler: instance A (GAP=1) and instance B (GAP=0) against a frame-level model.
module tb_piso_rr_scheduler;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         a_v0 = 1'b0, a_v1 = 1'b0, b_v0 = 1'b0, b_v1 = 1'b0;
  logic [W-1:0] a_d0 = '0, a_d1 = '0, b_d0 = '0, b_d1 = '0;
  logic         a_r0, a_r1, a_sdo, a_sv, a_src, a_fd, a_busy;
  logic         b_r0, b_r1, b_sdo, b_sv, b_src, b_fd, b_busy;
  logic [6:0]   obs_a, obs_b;

  assign obs_a = {a_r0, a_r1, a_sdo, a_sv, a_src, a_fd, a_busy};
  assign obs_b = {b_r0, b_r1, b_sdo, b_sv, b_src, b_fd, b_busy};

  piso_rr_scheduler #(.WIDTH(W), .GAP(1)) u_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .sdo(a_sdo), .sdo_valid(a_sv), .sdo_src(a_src), .frame_done(a_fd), .busy(a_busy)
  );

  piso_rr_scheduler #(.WIDTH(W), .GAP(0)) u_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .sdo(b_sdo), .sdo_valid(b_sv), .sdo_src(b_src), .frame_done(b_fd), .busy(b_busy)
  );

  // Model: per-cycle expected outputs live in a queue of {frame_done, bit} entries.
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           m_free [2];
  bit           m_last [2];
  bit           m_src  [2];
  logic [1:0]   qa [$];
  logic [1:0]   qb [$];
  bit           pend_hs  [2];
  bit           pend_who [2];
  logic [W-1:0] pend_d   [2];
  logic [6:0]   exp_v    [2];
  int           hsA_c [$];
  bit           hsA_w [$];
  int           hsB_c [$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_free[k] = 0;
      m_last[k] = 1'b1;
      m_src[k]  = 1'b0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic predict();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic v0, v1, who, bsy, hs, ev;
      logic [W-1:0] d0, d1;
      logic [1:0] e;
      v0 = (k == 0) ? a_v0 : b_v0;
      v1 = (k == 0) ? a_v1 : b_v1;
      d0 = (k == 0) ? a_d0 : b_d0;
      d1 = (k == 0) ? a_d1 : b_d1;
      ev = 1'b0;
      e  = 2'b00;
      if (k == 0 && qa.size() > 0) begin e = qa.pop_front(); ev = 1'b1; end
      if (k == 1 && qb.size() > 0) begin e = qb.pop_front(); ev = 1'b1; end
      bsy = (m_free[k] != 0);
      who = (v0 && v1) ? !m_last[k] : v1;
      hs  = !bsy && (v0 || v1);
      exp_v[k]    = {hs && !who, hs && who, ev && e[0], ev, m_src[k], ev && e[1], bsy};
      pend_hs[k]  = hs;
      pend_who[k] = who;
      pend_d[k]   = who ? d1 : d0;
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_free[k] = 0;
        m_last[k] = 1'b1;
        m_src[k]  = 1'b0;
        if (k == 0) qa.delete(); else qb.delete();
      end else begin
        if (m_free[k] > 0) m_free[k]--;
        if (pend_hs[k]) begin
          logic [W-1:0] dw;
          dw = pend_d[k];
          for (int i = W - 1; i >= 0; i--) begin
            if (k == 0) qa.push_back({i == 0, dw[i]});
            else        qb.push_back({i == 0, dw[i]});
          end
          m_free[k] = W + ((k == 0) ? 1 : 0);
          m_last[k] = pend_who[k];
          m_src[k]  = pend_who[k];
          if (k == 0) begin hsA_c.push_back(cyc); hsA_w.push_back(pend_who[k]); end
          else hsB_c.push_back(cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      predict();
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL reset_a cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      n_vec++;
      if (obs_b !== exp_v[1]) begin n_err++; $display("FAIL reset_b cyc=%0d got=%b exp=%b", cyc, obs_b, exp_v[1]); end
      commit();
    end
    reset = 1'b0;
  endtask

  task automatic test_single_req0();
    int nbusy;
    nbusy = 0;
    hsA_w.delete();
    a_v0 = 1'b1;
    a_d0 = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      predict();
      nbusy += (a_busy === 1'b1) ? 1 : 0;
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL single_req0 cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      commit();
      if (pend_hs[0]) a_v0 = 1'b0;
    end
    n_vec++;
    if (nbusy != 5) begin n_err++; $display("FAIL single_req0_busy_cycles got=%0d exp=5", nbusy); end
    n_vec++;
    if (hsA_w.size() != 1 || hsA_w[0] !== 1'b0) begin n_err++; $display("FAIL single_req0_grants got=%0d exp=1", hsA_w.size()); end
  endtask

  task automatic test_alternate();
    hsA_c.delete();
    hsA_w.delete();
    a_v0 = 1'b1; a_d0 = 4'b1100;
    a_v1 = 1'b1; a_d1 = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      reset = (i == 0);
      predict();
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL alternate cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      commit();
    end
    reset = 1'b0;
    a_v0 = 1'b0;
    a_v1 = 1'b0;
    n_vec++;
    if (hsA_c.size() < 3) begin
      n_err++; $display("FAIL alternate_count got=%0d exp>=3", hsA_c.size());
    end else begin
      n_vec++;
      if (hsA_c[1] - hsA_c[0] != 6 || hsA_c[2] - hsA_c[1] != 6) begin
        n_err++; $display("FAIL alternate_spacing got=%0d,%0d exp=6,6", hsA_c[1] - hsA_c[0], hsA_c[2] - hsA_c[1]);
      end
      n_vec++;
      if ({hsA_w[0], hsA_w[1], hsA_w[2]} !== 3'b010) begin
        n_err++; $display("FAIL alternate_order got=%b%b%b exp=010", hsA_w[0], hsA_w[1], hsA_w[2]);
      end
    end
  endtask

  task automatic test_req1_only();
    a_v1 = 1'b1;
    a_d1 = 4'b1001;
    for (int i = 0; i < 14; i++) begin
      predict();
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL req1_only cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      commit();
      if (pend_hs[0]) a_v1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    a_v0 = 1'b1;
    a_d0 = 4'b1011;
    for (int i = 0; i < 13; i++) begin
      reset = (i == 2);
      if (i == 4) begin a_v0 = 1'b1; a_d0 = 4'b0110; end
      predict();
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL reset_mid cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      if (i == 3) begin
        n_vec++;
        if ({a_sdo, a_sv, a_fd, a_busy} !== 4'b0000) begin
          n_err++; $display("FAIL reset_mid_abort got=%b exp=0000", {a_sdo, a_sv, a_fd, a_busy});
        end
      end
      commit();
      if (pend_hs[0] && !reset) a_v0 = 1'b0;
    end
    reset = 1'b0;
  endtask

  task automatic test_gap0();
    int nlow;
    nlow = 0;
    hsB_c.delete();
    b_v0 = 1'b1;
    b_d0 = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      predict();
      if (i >= 1 && i <= 14 && b_sv === 1'b0) nlow++;
      n_vec++;
      if (obs_b !== exp_v[1]) begin n_err++; $display("FAIL gap0 cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_b, exp_v[1]); end
      commit();
    end
    b_v0 = 1'b0;
    n_vec++;
    if (hsB_c.size() < 3 || hsB_c[1] - hsB_c[0] != 5 || hsB_c[2] - hsB_c[1] != 5) begin
      n_err++; $display("FAIL gap0_spacing got=%0d handshakes exp=every 5 cycles", hsB_c.size());
    end
    n_vec++;
    if (nlow != 2) begin n_err++; $display("FAIL gap0_valid_low got=%0d exp=2", nlow); end
  endtask

  task automatic test_data_change();
    logic [W-1:0] word;
    word = '0;
    a_v1 = 1'b1;
    a_d1 = 4'b0101;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin a_v0 = 1'b1; a_d0 = 4'b0001; end
      if (i == 3) a_d0 = 4'b1110;
      if (i == 5) a_d0 = 4'b1010;
      predict();
      if (i >= 7 && i <= 10) word = {word[W-2:0], a_sdo};
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL data_change cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      commit();
      if (pend_hs[0] && pend_who[0]) a_v1 = 1'b0;
      if (pend_hs[0] && !pend_who[0]) a_v0 = 1'b0;
    end
    n_vec++;
    if (word !== 4'b1010) begin n_err++; $display("FAIL data_change_word got=%b exp=1010", word); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      a_v0 = $urandom_range(0, 2) != 0;
      a_v1 = $urandom_range(0, 2) != 0;
      b_v0 = $urandom_range(0, 1) != 0;
      b_v1 = $urandom_range(0, 1) != 0;
      a_d0 = W'($urandom);
      a_d1 = W'($urandom);
      b_d0 = W'($urandom);
      b_d1 = W'($urandom);
      predict();
      n_vec++;
      if (obs_a !== exp_v[0]) begin n_err++; $display("FAIL random_a cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_a, exp_v[0]); end
      n_vec++;
      if (obs_b !== exp_v[1]) begin n_err++; $display("FAIL random_b cyc=%0d got=%b exp=%b (r0 r1 sdo sv src fd busy)", cyc, obs_b, exp_v[1]); end
      commit();
    end
    reset = 1'b0;
    a_v0 = 1'b0; a_v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_req0();
    test_alternate();
    test_req1_only();
    test_reset_mid_frame();
    test_gap0();
    test_data_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_rr_scheduler.md
Name: piso_rr_scheduler

Overview:
Shares one parallel-in/serial-out serializer between two word requesters.
- Round-robin arbitration between requesters.
- Loads the granted word into the internal shift register, shifts it out MSB-first with a valid strobe, then inserts a programmable idle gap.
- Sits between parallel producers and a single-wire serial link. Replaces free-running preload/shift sequencing with a handshaked, counted frame controller.

Parameters:
WIDTH, 4, bits per word / serial frame length (>=2)
GAP, 1, idle cycles after each frame before the next grant (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle (valid&&ready)
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle
sdo  output  1  serial data out, MSB first
sdo_valid  output  1  sdo carries a frame bit
sdo_src  output  1  requester index owning the current/last frame
frame_done  output  1  one-cycle pulse coincident with the last bit of a frame
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled on the rising edge.
- Reset values, all registered: state=IDLE, shift register=0, bit counter=0, gap counter=0, sdo=0, sdo_valid=0, sdo_src=0, frame_done=0, last_grant=1 (so requester 0 wins the first tie).
- Reset mid-frame: aborts immediately, no frame_done pulse, partially shifted word discarded.
- FSM states: IDLE -> SHIFT -> GAP -> IDLE.
  - GAP is skipped when GAP=0: SHIFT -> IDLE directly.
- Arbitration, IDLE only:
  - Exactly one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: stay in IDLE, all readies low.
- Ready:
  - reqN_ready = (state==IDLE) && reqN_valid && granted(N).
  - Combinational from registered state and the inputs. At most one ready high per cycle.
- Handshake cycle T (valid&&ready):
  - Capture data into the shift register; set sdo_src=N and last_grant=N; state<=SHIFT.
  - Requesters must hold valid and data stable until ready; data is sampled only at the handshake.
- SHIFT, cycles T+1 .. T+WIDTH:
  - sdo = data[WIDTH-1] at T+1, down to data[0] at T+WIDTH; sdo_valid=1 throughout.
  - The register shifts left, filling with 0.
  - frame_done=1 only at T+WIDTH.
- GAP: sdo=0, sdo_valid=0 for GAP cycles, then IDLE.
- Frame period:
  - Earliest next handshake is at T+WIDTH+GAP+1.
  - Each frame occupies WIDTH+GAP+1 cycles under continuous requests.
- Outside SHIFT: sdo=0, sdo_valid=0. sdo_src holds its last value.
- Input changes outside the handshake cycle: valid dropping, or data changing while not ready, have no effect.
- Width rules:
  - Bit counter is clog2(WIDTH+1) bits.
  - Gap counter is 4 bits.
  - No wrap-around of either counter is permitted.

Test Plan:
1. Reset, then req0_valid=1, data=4'b0101 (WIDTH=4, GAP=1) -> req0_ready high 1 cycle; sdo=0,1,0,1 on the next 4 cycles with sdo_valid=1; frame_done on the 4th; sdo_src=0; busy high 5 cycles.
2. Both valid from reset (0=4'b1100, 1=4'b0011), both held -> grants alternate 0,1,0; handshakes exactly 6 cycles apart; serial stream 1100 / 0011 / 1100.
3. Only req1_valid (4'b1001) -> req1_ready, sdo 1,0,0,1, sdo_src=1; req0_ready stays 0.
4. reset asserted on the 2nd SHIFT bit -> next cycle sdo=0, sdo_valid=0, busy=0, no frame_done; a following req0 request is served normally.
5. GAP=0 with req0 held at 4'b1111 -> handshake every 5 cycles; sdo_valid low exactly 1 cycle (the IDLE/handshake cycle) between frames.
6. req0_data changed while req0 is waiting during another frame -> the value present at the handshake cycle is the one serialized.
